// File: rtl/eth_mac_tx_arbiter_pkg.sv
// Shared arbiter state encoding for the MAC TX arbiter.
package eth_mac_tx_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/eth_mac_tx_arbiter_if.sv
// AXI-stream bundle between S_COUNT sources, the arbiter and the MAC TX input.
interface eth_mac_tx_arbiter_if #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic [S_COUNT-1:0]            s_axis_tvalid;
  logic [S_COUNT-1:0]            s_axis_tready;
  logic [S_COUNT-1:0]            s_axis_tlast;
  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;
  logic [USER_WIDTH-1:0]         m_axis_tuser;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/eth_rr_select.sv
// Combinational round-robin pick: first requester at or cyclically after ptr_i.
module eth_rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  logic             hi_valid;
  logic [IDX_W-1:0] hi_idx;
  logic             lo_valid;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan leaves the lowest match; hi_* only counts indices at/after the pointer.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_valid = 1'b0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_valid = 1'b1;
        lo_idx   = IDX_W'(i);
        if (IDX_W'(i) >= ptr_i) begin
          hi_valid = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    valid_o = lo_valid;
    index_o = hi_valid ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/eth_mac_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the MAC TX stream through a 2-entry skid buffer.
module eth_mac_tx_arbiter
  import eth_mac_tx_arbiter_pkg::*;
#(
  parameter int  S_COUNT    = 2,
  parameter int  DATA_WIDTH = 8,
  parameter int  USER_WIDTH = 1,
  localparam int CL_S_COUNT = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  eth_mac_tx_arbiter_if.slave   axis,
  output logic                  grant_valid,
  output logic [CL_S_COUNT-1:0] grant_index,
  output logic                  frame_done,
  output logic [CL_S_COUNT-1:0] frame_done_index
);

  arb_state_e              state_q, state_d;
  logic [CL_S_COUNT-1:0]   rr_q, rr_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [CL_S_COUNT-1:0]   grant_index_q, grant_index_d;
  logic                    ready_q, ready_d;
  logic                    frame_done_q, frame_done_d;
  logic [CL_S_COUNT-1:0]   frame_done_index_q, frame_done_index_d;

  logic                    sel_valid;
  logic [CL_S_COUNT-1:0]   sel_index;

  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_last;
  logic [USER_WIDTH-1:0]   in_user;
  logic                    accept;
  logic                    room;

  logic                    m_valid_q, temp_valid_q;
  logic                    m_last_q, temp_last_q;
  logic [DATA_WIDTH-1:0]   m_data_q, temp_data_q;
  logic [USER_WIDTH-1:0]   m_user_q, temp_user_q;

  eth_rr_select #(.N(S_COUNT), .IDX_W(CL_S_COUNT)) u_rr_select (
    .req_i   (axis.s_axis_tvalid),
    .ptr_i   (rr_q),
    .valid_o (sel_valid),
    .index_o (sel_index)
  );

  always_comb begin
    in_data             = '0;
    in_valid            = 1'b0;
    in_last             = 1'b0;
    in_user             = '0;
    axis.s_axis_tready  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index_q == CL_S_COUNT'(i)) begin
        in_data               = axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        in_valid              = axis.s_axis_tvalid[i];
        in_last               = axis.s_axis_tlast[i];
        in_user               = axis.s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        axis.s_axis_tready[i] = ready_q;
      end
    end
  end

  // ready_q is only ever set while BUSY, so it alone qualifies an accepted beat.
  assign accept = ready_q & in_valid;
  assign room   = axis.m_axis_tready | (~temp_valid_q & (~m_valid_q | ~accept));

  always_comb begin
    state_d            = state_q;
    rr_d               = rr_q;
    grant_valid_d      = grant_valid_q;
    grant_index_d      = grant_index_q;
    ready_d            = 1'b0;
    frame_done_d       = 1'b0;
    frame_done_index_d = frame_done_index_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d       = ST_BUSY;
          grant_valid_d = 1'b1;
          grant_index_d = sel_index;
          ready_d       = room;
        end
      end
      ST_BUSY: begin
        if (accept && in_last) begin
          state_d            = ST_IDLE;
          grant_valid_d      = 1'b0;
          rr_d               = (grant_index_q == CL_S_COUNT'(S_COUNT - 1)) ? '0
                                                                           : grant_index_q + 1'b1;
          frame_done_d       = 1'b1;
          frame_done_index_d = grant_index_q;
        end else begin
          ready_d = room;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      rr_q               <= '0;
      grant_valid_q      <= 1'b0;
      grant_index_q      <= '0;
      ready_q            <= 1'b0;
      frame_done_q       <= 1'b0;
      frame_done_index_q <= '0;
    end else begin
      state_q            <= state_d;
      rr_q               <= rr_d;
      grant_valid_q      <= grant_valid_d;
      grant_index_q      <= grant_index_d;
      ready_q            <= ready_d;
      frame_done_q       <= frame_done_d;
      frame_done_index_q <= frame_done_index_d;
    end
  end

  // Skid buffer: an accepted beat lands in the output reg when it is free or draining,
  // otherwise in temp; temp refills the output once the MAC takes the current beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      m_user_q     <= '0;
      temp_valid_q <= 1'b0;
      temp_last_q  <= 1'b0;
      temp_data_q  <= '0;
      temp_user_q  <= '0;
    end else if (ready_q) begin
      if (axis.m_axis_tready || !m_valid_q) begin
        m_valid_q <= in_valid;
        m_last_q  <= in_last;
        m_data_q  <= in_data;
        m_user_q  <= in_user;
      end else begin
        temp_valid_q <= in_valid;
        temp_last_q  <= in_last;
        temp_data_q  <= in_data;
        temp_user_q  <= in_user;
      end
    end else if (axis.m_axis_tready || !m_valid_q) begin
      m_valid_q    <= temp_valid_q;
      m_last_q     <= temp_last_q;
      m_data_q     <= temp_data_q;
      m_user_q     <= temp_user_q;
      temp_valid_q <= 1'b0;
    end
  end

  assign axis.m_axis_tvalid = m_valid_q;
  assign axis.m_axis_tlast  = m_last_q;
  assign axis.m_axis_tdata  = m_data_q;
  assign axis.m_axis_tuser  = m_user_q;
  assign grant_valid        = grant_valid_q;
  assign grant_index        = grant_index_q;
  assign frame_done         = frame_done_q;
  assign frame_done_index   = frame_done_index_q;

endmodule

// File: tb/tb_eth_mac_tx_arbiter.sv
// Bench for eth_mac_tx_arbiter: queued source frames, round-robin frame-order model, per-cycle compare.
module tb_eth_mac_tx_arbiter;
  localparam int S  = 3;
  localparam int DW = 8;
  localparam int UW = 1;
  localparam int CL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          grant_valid;
  logic [CL-1:0] grant_index;
  logic          frame_done;
  logic [CL-1:0] frame_done_index;

  eth_mac_tx_arbiter_if #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW)) axis ();

  eth_mac_tx_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk              (clk),
    .rst              (rst),
    .axis             (axis.slave),
    .grant_valid      (grant_valid),
    .grant_index      (grant_index),
    .frame_done       (frame_done),
    .frame_done_index (frame_done_index)
  );

  always #5 clk = ~clk;

  // Beat encoding everywhere in the bench: {user, last, data[7:0]}.
  logic [9:0] sq [S][$];
  logic [9:0] exp_q[$];
  int         exp_src[$];
  logic [9:0] cap_q[$];
  int         cap_fd[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         mdl_ptr = 0;
  int         acc_cnt = 0;
  int         out_cnt = 0;
  int         mrdy_mode = 0;
  bit         gaps_en = 0;
  int         gap_once[S];
  int         gap[S];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  task automatic push_beat(input int s, input logic [7:0] d, input logic last, input logic user);
    sq[s].push_back({user, last, d});
  endtask

  task automatic push_frame(input int s, input int n, input logic [7:0] base, input logic user_last);
    for (int i = 0; i < n; i++)
      push_beat(s, base + 8'(i), (i == n - 1), (i == n - 1) ? user_last : 1'b0);
  endtask

  // Reference: whole frames leave in round-robin order over sources holding frames.
  task automatic predict();
    int pos[S];
    int c;
    bit found;
    logic [9:0] b;
    for (int s = 0; s < S; s++) pos[s] = 0;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      c = 0;
      for (int k = 0; k < S; k++) begin
        if (!found && pos[(mdl_ptr + k) % S] < sq[(mdl_ptr + k) % S].size()) begin
          found = 1'b1;
          c = (mdl_ptr + k) % S;
        end
      end
      if (found) begin
        exp_src.push_back(c);
        do begin
          b = sq[c][pos[c]];
          pos[c]++;
          exp_q.push_back(b);
        end while (!b[8]);
        mdl_ptr = (c + 1) % S;
      end
    end
  endtask

  function automatic bit sources_busy();
    for (int s = 0; s < S; s++) if (sq[s].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while ((exp_q.size() > 0 || exp_src.size() > 0 || sources_busy()) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) fail_now({name, "_timeout"});
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic new_test();
    cap_q.delete();
    cap_fd.delete();
  endtask

  // Source drivers: hold each beat until taken; gaps only occur inside a frame.
  initial begin : drv
    logic [S-1:0] fire;
    logic [9:0]   b;
    for (int s = 0; s < S; s++) begin gap[s] = 0; gap_once[s] = 0; end
    axis.s_axis_tvalid = '0;
    axis.s_axis_tdata  = '0;
    axis.s_axis_tlast  = '0;
    axis.s_axis_tuser  = '0;
    forever begin
      @(negedge clk);
      fire = axis.s_axis_tvalid & axis.s_axis_tready;
      @(posedge clk);
      #1;
      for (int s = 0; s < S; s++) begin
        if (rst) gap[s] = 0;
        else if (fire[s] && sq[s].size() > 0) begin
          b = sq[s].pop_front();
          if (!b[8]) begin
            if (gap_once[s] > 0) begin gap[s] = gap_once[s]; gap_once[s] = 0; end
            else if (gaps_en) gap[s] = $urandom_range(0, 3);
          end
        end else if (gap[s] > 0) gap[s]--;
        axis.s_axis_tvalid[s] = (sq[s].size() > 0) && (gap[s] == 0);
        if (sq[s].size() > 0) begin
          b = sq[s][0];
          axis.s_axis_tdata[s*DW +: DW] = b[7:0];
          axis.s_axis_tlast[s]          = b[8];
          axis.s_axis_tuser[s]          = b[9];
        end else begin
          axis.s_axis_tlast[s] = 1'b0;
          axis.s_axis_tuser[s] = 1'b0;
        end
      end
    end
  end

  initial begin : mrdy
    axis.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mrdy_mode)
        0:       axis.m_axis_tready = 1'b1;
        1:       axis.m_axis_tready = ~axis.m_axis_tready;
        default: axis.m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Per-cycle compare against the reference streams.
  initial begin : mon
    logic        prev_stall;
    logic [10:0] prev_m;
    logic [10:0] cur_m;
    logic [9:0]  e;
    logic [S-1:0] mask;
    prev_stall = 1'b0;
    prev_m     = '0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else begin
        cur_m = {axis.m_axis_tvalid, axis.m_axis_tuser, axis.m_axis_tlast, axis.m_axis_tdata};
        if (prev_stall) check("m_hold_while_stalled", cur_m, prev_m);
        check("buffer_occupancy_le2", (acc_cnt - out_cnt <= 2), 1);
        if (axis.m_axis_tvalid && axis.m_axis_tready) begin
          out_cnt++;
          cap_q.push_back({axis.m_axis_tuser, axis.m_axis_tlast, axis.m_axis_tdata});
          if (exp_q.size() == 0) fail_now("unexpected_m_beat");
          else begin
            e = exp_q.pop_front();
            check("m_beat", {axis.m_axis_tuser, axis.m_axis_tlast, axis.m_axis_tdata}, e);
          end
        end
        acc_cnt += $countones(axis.s_axis_tvalid & axis.s_axis_tready);
        mask = '0;
        if (grant_valid) mask[grant_index] = 1'b1;
        check("s_tready_only_owner", axis.s_axis_tready & ~mask, 0);
        if (grant_valid) begin
          if (exp_src.size() == 0) fail_now("unexpected_grant");
          else check("grant_index", grant_index, exp_src[0]);
        end
        if (frame_done) begin
          cap_fd.push_back(int'(frame_done_index));
          if (exp_src.size() == 0) fail_now("unexpected_frame_done");
          else check("frame_done_index", frame_done_index, exp_src.pop_front());
        end
        prev_stall = axis.m_axis_tvalid & ~axis.m_axis_tready;
        prev_m     = cur_m;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, axis.s_axis_tready, 0);
    check({tag, "_m_tvalid"}, axis.m_axis_tvalid, 0);
    check({tag, "_m_tlast"}, axis.m_axis_tlast, 0);
    check({tag, "_m_tdata"}, axis.m_axis_tdata, 0);
    check({tag, "_m_tuser"}, axis.m_axis_tuser, 0);
    check({tag, "_grant_valid"}, grant_valid, 0);
    check({tag, "_grant_index"}, grant_index, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin : main
    logic [9:0] e2[4];
    int         fd4[6];
    int         nf;
    int         n;
    int         t;
    e2  = '{10'h011, 10'h022, 10'h033, 10'h144};
    fd4 = '{1, 2, 0, 1, 2, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    #2;

    // Single 4-byte frame from src1, with first-beat timing.
    new_test();
    push_beat(1, 8'h11, 1'b0, 1'b0);
    push_beat(1, 8'h22, 1'b0, 1'b0);
    push_beat(1, 8'h33, 1'b0, 1'b0);
    push_beat(1, 8'h44, 1'b1, 1'b0);
    predict();
    @(negedge clk); #2;
    check("arb_cycle_no_grant", grant_valid, 0);
    @(negedge clk); #2;
    check("grant_after_arb", grant_valid, 1);
    check("grant_after_arb_idx", grant_index, 1);
    check("s_tready_src1", axis.s_axis_tready, 3'b010);
    check("m_empty_before_first", axis.m_axis_tvalid, 0);
    @(negedge clk); #2;
    check("first_beat_valid", axis.m_axis_tvalid, 1);
    check("first_beat_data", axis.m_axis_tdata, 8'h11);
    wait_drain("src1_frame", 100);
    check("src1_beats", cap_q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < cap_q.size()) check("src1_beat_lit", cap_q[i], e2[i]);
    check("src1_done_count", cap_fd.size(), 1);
    if (cap_fd.size() > 0) check("src1_done_idx", cap_fd[0], 1);
    check("model_ptr_after_src1", mdl_ptr, 2);

    // Pointer sits at 2: src2 must beat src0.
    new_test();
    push_beat(0, 8'hAA, 1'b1, 1'b0);
    push_beat(2, 8'hBB, 1'b1, 1'b0);
    predict();
    wait_drain("ptr2", 100);
    if (cap_q.size() > 0) check("ptr2_first_beat", cap_q[0], 10'h1BB);
    check("ptr2_done_count", cap_fd.size(), 2);
    if (cap_fd.size() == 2) begin
      check("ptr2_done0", cap_fd[0], 2);
      check("ptr2_done1", cap_fd[1], 0);
    end

    // All sources busy with 2-beat frames.
    new_test();
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < S; s++) push_frame(s, 2, 8'(16 * s + 4 * f), 1'b0);
    predict();
    wait_drain("rr_all", 300);
    check("rr_done_count", cap_fd.size(), 6);
    for (int i = 0; i < 6; i++) if (i < cap_fd.size()) check("rr_order", cap_fd[i], fd4[i]);

    // 64-byte frame with m_axis_tready toggling every cycle.
    new_test();
    mrdy_mode = 1;
    push_frame(1, 64, 8'h00, 1'b0);
    predict();
    wait_drain("toggle64", 400);
    mrdy_mode = 0;
    check("toggle64_len", cap_q.size(), 64);
    for (int i = 0; i < 64; i++)
      if (i < cap_q.size()) check("toggle64_beat", cap_q[i], {1'b0, (i == 63), 8'(i)});

    // tuser flagged on the tlast beat only.
    new_test();
    push_beat(0, 8'h5A, 1'b0, 1'b0);
    push_beat(0, 8'hA5, 1'b1, 1'b1);
    predict();
    wait_drain("tuser", 100);
    check("tuser_len", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      check("tuser_beat0", cap_q[0], 10'h05A);
      check("tuser_beat1", cap_q[1], 10'h3A5);
    end

    // src2 stalls 5 cycles mid-frame while src0 waits.
    new_test();
    gap_once[2] = 5;
    push_frame(2, 8, 8'h80, 1'b0);
    push_frame(0, 4, 8'hC0, 1'b0);
    predict();
    wait_drain("gap", 200);
    check("gap_done_count", cap_fd.size(), 2);
    if (cap_fd.size() == 2) begin
      check("gap_done0", cap_fd[0], 2);
      check("gap_done1", cap_fd[1], 0);
    end

    // Randomized traffic, random stalls on both sides.
    gaps_en   = 1'b1;
    mrdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      new_test();
      for (int s = 0; s < S; s++) begin
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          n = $urandom_range(1, 8);
          for (int i = 0; i < n; i++)
            push_beat(s, 8'($urandom), (i == n - 1), 1'($urandom));
        end
      end
      predict();
      wait_drain("random", 3000);
    end
    gaps_en   = 1'b0;
    mrdy_mode = 0;

    // Reset on byte 10 of a src2 frame, then a clean src0 frame.
    new_test();
    push_frame(2, 16, 8'h20, 1'b0);
    predict();
    t = acc_cnt;
    n = 0;
    while (acc_cnt - t < 10 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= 200) fail_now("reset_trigger_timeout");
    rst = 1'b1;
    sq[2].delete();
    exp_q.delete();
    exp_src.delete();
    mdl_ptr = 0;
    @(negedge clk); #2;
    check_reset_outputs("midframe_reset");
    acc_cnt = 0;
    out_cnt = 0;
    rst = 1'b0;
    @(negedge clk); #2;
    new_test();
    push_frame(0, 6, 8'h60, 1'b0);
    predict();
    wait_drain("post_reset", 100);
    check("post_reset_len", cap_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < cap_q.size()) check("post_reset_beat", cap_q[i], {1'b0, (i == 5), 8'(8'h60 + i)});
    check("post_reset_done_count", cap_fd.size(), 1);
    if (cap_fd.size() > 0) check("post_reset_done_idx", cap_fd[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
